fft_peak_detect: RTL and testbench

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_pwr.sv | 56 +++++
 rtl/fft_peak_detect.sv | 152 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector.
// Default frame size, sample width and derived bin/power widths.
// FSM state encoding used by the frame accumulator.
package fft_pkg;
  localparam int N_DEF  = 256;
  localparam int DW_DEF = 16;
  localparam int BIN_W  = $clog2(N_DEF);
  localparam int PWR_W  = 2 * DW_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;
endpackage

// File: rtl/fft_pwr.sv
// Squared magnitude re^2 + im^2 of a signed complex sample, unsigned 2*DW result.
// Latency: 2 cycles (squares register, then sum register); valid follows the data.
// No backpressure: accepts one sample per cycle whenever valid_in is high.
module fft_pwr
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DW-1:0]     d_re,
  input  logic [DW-1:0]     d_im,
  output logic              valid_out,
  output logic [2*DW-1:0]   pwr
);

  // Sign-extend to the product width so the multiply is full precision.
  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] re_sq_c;
  logic signed [2*DW-1:0] im_sq_c;
  logic        [2*DW-1:0] re_sq;
  logic        [2*DW-1:0] im_sq;
  logic                   vld1;

  assign re_x    = {{DW{d_re[DW-1]}}, d_re};
  assign im_x    = {{DW{d_im[DW-1]}}, d_im};
  assign re_sq_c = re_x * re_x;
  assign im_sq_c = im_x * im_x;

  // Stage 1: register the two squares (each at most 2^(2DW-2), always non-negative).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sq <= '0;
      im_sq <= '0;
      vld1  <= 1'b0;
    end else begin
      re_sq <= re_sq_c;
      im_sq <= im_sq_c;
      vld1  <= valid_in;
    end
  end

  // Stage 2: register the sum; worst case 2^(2DW-1) still fits unsigned 2*DW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr       <= '0;
      valid_out <= 1'b0;
    end else begin
      pwr       <= re_sq + im_sq;
      valid_out <= vld1;
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Finds the maximum-power bin of each N-bin FFT frame (lowest bin wins ties).
// Latency: done pulses 3 edges after the edge that samples bin N-1.
// No backpressure: valid_in low is a stall; an early sop_in aborts and restarts.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic [DW-1:0]        d_re,
  input  logic [DW-1:0]        d_im,
  output logic                 done,
  output logic [$clog2(N)-1:0] peak_bin,
  output logic [2*DW-1:0]      peak_pwr,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIN = BW'(N - 1);

  state_t          state, state_nx;
  logic [BW-1:0]   cnt, cnt_nx;
  logic            take, abort, bin_last;
  logic [BW-1:0]   bin_idx;

  // Tags travelling alongside the power pipeline.
  logic            t1_first, t1_last, t2_first, t2_last;
  logic [BW-1:0]   t1_bin, t2_bin;
  logic            p_vld;
  logic [2*DW-1:0] p;

  logic [2*DW-1:0] max_pwr;
  logic [BW-1:0]   max_bin;
  logic            fin;

  // State register and next-expected-bin counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: accept sop in IDLE, count bins in ACC, restart on early sop.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    abort    = 1'b0;
    bin_last = 1'b0;
    bin_idx  = cnt;
    case (state)
      IDLE: begin
        if (valid_in && sop_in) begin
          take     = 1'b1;
          bin_idx  = '0;
          state_nx = ACC;
          cnt_nx   = BW'(1);
        end
      end
      ACC: begin
        if (valid_in) begin
          take = 1'b1;
          if (sop_in) begin
            abort   = 1'b1;
            bin_idx = '0;
            cnt_nx  = BW'(1);
          end else if (cnt == LAST_BIN) begin
            bin_last = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + BW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == ACC);

  fft_pwr #(.DW(DW)) u_pwr (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (take),
    .d_re      (d_re),
    .d_im      (d_im),
    .valid_out (p_vld),
    .pwr       (p)
  );

  // Delay the bin tags by the same two stages as the power pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_first <= 1'b0;
      t1_last  <= 1'b0;
      t1_bin   <= '0;
      t2_first <= 1'b0;
      t2_last  <= 1'b0;
      t2_bin   <= '0;
    end else begin
      t1_first <= take && sop_in;
      t1_last  <= bin_last;
      t1_bin   <= bin_idx;
      t2_first <= t1_first;
      t2_last  <= t1_last;
      t2_bin   <= t1_bin;
    end
  end

  // Running maximum: bin 0 always loads, later bins only on strictly greater power.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_pwr <= '0;
      max_bin <= '0;
      fin     <= 1'b0;
    end else begin
      if (p_vld && (t2_first || (p > max_pwr))) begin
        max_pwr <= p;
        max_bin <= t2_bin;
      end
      fin <= p_vld && t2_last;
    end
  end

  // Publish the finished frame's peak with done; abort pulses frame_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      peak_bin  <= '0;
      peak_pwr  <= '0;
      frame_err <= 1'b0;
    end else begin
      done      <= fin;
      frame_err <= abort;
      if (fin) begin
        peak_bin <= max_bin;
        peak_pwr <= max_pwr;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: expected peaks queued as frames are driven,
// popped and compared when done pulses.
module tb_fft_peak_detect;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic               sop_in = 1'b0;
  logic signed [15:0] d_re = '0;
  logic signed [15:0] d_im = '0;
  logic               done;
  logic [7:0]         peak_bin;
  logic [31:0]        peak_pwr;
  logic               frame_err;
  logic               busy;

  fft_peak_detect #(.N(256), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .d_re      (d_re),
    .d_im      (d_im),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_pwr  (peak_pwr),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  bin;
    logic [31:0] pwr;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   err_cyc  = 0;
  int   first_cyc = 0;
  int   fre[256];
  int   fim[256];

  // Reference peak search over the current frame arrays.
  task automatic model_peak(output logic [7:0] b, output logic [31:0] p);
    longint best = -1;
    longint q;
    b = '0;
    for (int i = 0; i < 256; i++) begin
      q = longint'(fre[i]) * longint'(fre[i]) + longint'(fim[i]) * longint'(fim[i]);
      if (q > best) begin
        best = q;
        b = i[7:0];
      end
    end
    p = best[31:0];
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 256; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic fill_rand(input int amp);
    for (int i = 0; i < 256; i++) begin
      fre[i] = int'($urandom_range(2 * amp)) - amp;
      fim[i] = int'($urandom_range(2 * amp)) - amp;
    end
  endtask

  task automatic drive_bin(input logic v, input logic s, input int re, input int im);
    @(negedge clk);
    valid_in = v;
    sop_in   = s;
    d_re     = re[15:0];
    d_im     = im[15:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bin(1'b0, 1'b0, 0, 0);
  endtask

  // Drive a full frame; gap idle cycles between valid bins (none after the last).
  task automatic send_frame(input int gap);
    exp_t e;
    model_peak(e.bin, e.pwr);
    for (int b = 0; b < 256; b++) begin
      drive_bin(1'b1, b == 0, fre[b], fim[b]);
      if (b == 0) first_cyc = cyc + 1;
      if (b == 255) begin
        e.due = cyc + 4;
        sb.push_back(e);
      end
      if (b != 255) for (int g = 0; g < gap; g++) drive_bin(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() > 0 && k < 50) begin
      drive_bin(1'b0, 1'b0, 0, 0);
      k++;
    end
    idle(2);
    chk_cnt++;
    if (sb.size() != 0) begin
      $display("FAIL %s_timeout: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end else pass_cnt++;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) begin
          err_cnt++;
          err_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_q.push_back(cyc);
          if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
          end else begin
            e = sb.pop_front();
            chk_cnt++;
            if (peak_bin !== e.bin)
              $display("FAIL sb_peak_bin: got %0d expected %0d", peak_bin, e.bin);
            else pass_cnt++;
            chk_cnt++;
            if (peak_pwr !== e.pwr)
              $display("FAIL sb_peak_pwr: got %0d expected %0d", peak_pwr, e.pwr);
            else pass_cnt++;
            chk_cnt++;
            if (cyc !== e.due)
              $display("FAIL sb_done_cycle: got %0d expected %0d", cyc, e.due);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL %s_done: got %b expected 0", name, done); else pass_cnt++;
    chk_cnt++;
    if (frame_err !== 1'b0) $display("FAIL %s_frame_err: got %b expected 0", name, frame_err); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy: got %b expected 0", name, busy); else pass_cnt++;
    chk_cnt++;
    if (peak_bin !== 8'd0) $display("FAIL %s_peak_bin: got %0d expected 0", name, peak_bin); else pass_cnt++;
    chk_cnt++;
    if (peak_pwr !== 32'd0) $display("FAIL %s_peak_pwr: got %0d expected 0", name, peak_pwr); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    fill_zero();
    fre[37] = 1000;
    fim[37] = -2000;
    send_frame(0);
    drive_bin(1'b0, 1'b0, 0, 0);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy_after: got %b expected 0", busy); else pass_cnt++;
    wait_drain("single");
    chk_cnt++;
    if (peak_bin !== 8'd37) $display("FAIL single_bin: got %0d expected 37", peak_bin); else pass_cnt++;
    chk_cnt++;
    if (peak_pwr !== 32'd5000000) $display("FAIL single_pwr: got %0d expected 5000000", peak_pwr); else pass_cnt++;
  endtask

  task automatic test_overflow();
    fill_zero();
    fre[10] = -32768; fim[10] = -32768;
    fre[200] = -32768; fim[200] = -32768;
    send_frame(0);
    wait_drain("overflow");
    chk_cnt++;
    if (peak_bin !== 8'd10) $display("FAIL overflow_bin: got %0d expected 10", peak_bin); else pass_cnt++;
    chk_cnt++;
    if (peak_pwr !== 32'h8000_0000) $display("FAIL overflow_pwr: got %0d expected 2147483648", peak_pwr); else pass_cnt++;
  endtask

  task automatic test_toggle();
    fill_zero();
    fre[37] = 1000;
    fim[37] = -2000;
    send_frame(1);
    wait_drain("toggle");
    chk_cnt++;
    if (peak_bin !== 8'd37) $display("FAIL toggle_bin: got %0d expected 37", peak_bin); else pass_cnt++;
  endtask

  task automatic test_abort();
    int e0, d0;
    fill_rand(32767);
    for (int b = 0; b < 100; b++) drive_bin(1'b1, b == 0, fre[b], fim[b]);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL abort_busy_mid: got %b expected 1", busy); else pass_cnt++;
    e0 = err_cnt;
    d0 = done_cnt;
    fill_rand(20);
    fre[5] = 3000;
    fim[5] = -3000;
    send_frame(0);
    idle(1);
    wait_drain("abort");
    chk_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL abort_err_count: got %0d expected 1", err_cnt - e0); else pass_cnt++;
    chk_cnt++;
    if (err_cyc !== first_cyc) $display("FAIL abort_err_cycle: got %0d expected %0d", err_cyc, first_cyc); else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL abort_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++;
    if (peak_bin !== 8'd5) $display("FAIL abort_bin: got %0d expected 5", peak_bin); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d0, gapc;
    d0 = done_cnt;
    fill_rand(50);
    fre[3] = 9000; fim[3] = 100;
    send_frame(0);
    fill_rand(50);
    fre[250] = -7000; fim[250] = 7000;
    send_frame(0);
    wait_drain("b2b");
    chk_cnt++;
    if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); else pass_cnt++;
    gapc = (done_q.size() >= 2) ? done_q[done_q.size()-1] - done_q[done_q.size()-2] : -1;
    chk_cnt++;
    if (gapc !== 256) $display("FAIL b2b_done_spacing: got %0d expected 256", gapc); else pass_cnt++;
    chk_cnt++;
    if (peak_bin !== 8'd250) $display("FAIL b2b_last_bin: got %0d expected 250", peak_bin); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0;
    logic bad;
    fill_rand(32767);
    for (int b = 0; b <= 128; b++) drive_bin(1'b1, b == 0, fre[b], fim[b]);
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    sop_in = 1'b0;
    idle(2);
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_bin(1'b1, 1'b0, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    idle(6);
    chk_cnt++;
    if (bad !== 1'b0) $display("FAIL nosop_busy_or_done: got %b expected 0", bad); else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL nosop_done_count: got %0d expected 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++;
    if (peak_bin !== 8'd0) $display("FAIL nosop_peak_bin: got %0d expected 0", peak_bin); else pass_cnt++;
    chk_cnt++;
    if (peak_pwr !== 32'd0) $display("FAIL nosop_peak_pwr: got %0d expected 0", peak_pwr); else pass_cnt++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_overflow();
    test_toggle();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
